// File: rtl/keypad_col_scanner.sv
// Column-side 4x4 keypad scanner: walks the columns, resolves the pressed key, and waits for release.
// Define KEYPAD_REPEAT_EN to emit auto-repeat key_valid pulses every REPEAT_CYCLES while the key stays held.
module keypad_col_scanner #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Row,
    input  logic       S_Row,
    output logic [3:0] Col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       scan_miss,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255 || SETTLE_CYCLES > (1 << CNT_W) ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > (1 << CNT_W)) begin : g_param_check
        $error("keypad_col_scanner: illegal SETTLE_CYCLES, REPEAT_CYCLES or CNT_W");
    end

    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic [1:0]       state;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       row_idx;
    logic             settle_done;
    logic             miss;
    logic             repeat_fire;

    assign settle_done = (state == SCAN) && (cnt == SETTLE_LAST);
    assign miss        = settle_done && (row_s == 4'b0000) && (col_idx == 2'd3);

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    assign repeat_fire = (state == HOLD) && S_Row && (cnt == REPEAT_LAST);
`else
    assign repeat_fire = 1'b0;
`endif

    // Lowest active row wins when several rows respond in the same column.
    always_comb begin
        row_idx = 2'd0;
        if (row_s[3]) row_idx = 2'd3;
        if (row_s[2]) row_idx = 2'd2;
        if (row_s[1]) row_idx = 2'd1;
        if (row_s[0]) row_idx = 2'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta <= 4'b0000;
            row_s    <= 4'b0000;
            state    <= IDLE;
            col_idx  <= 2'd0;
            cnt      <= '0;
            key_code <= 4'd0;
        end else begin
            row_meta <= Row;
            row_s    <= row_meta;
            case (state)
                IDLE: begin
                    if (S_Row) begin
                        state   <= SCAN;
                        col_idx <= 2'd0;
                        cnt     <= '0;
                    end
                end
                SCAN: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (row_s != 4'b0000) begin
                            key_code <= {row_idx, col_idx};
                            state    <= REPORT;
                        end else if (col_idx != 2'd3) begin
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPORT: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: begin
                    if (!S_Row) begin
                        state <= IDLE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (cnt == REPEAT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are gated by reset so an abort in the same cycle never leaks a pulse.
    always_comb begin
        Col = 4'b1111;
        if (!reset && state == SCAN) Col = 4'b0001 << col_idx;
    end

    assign key_valid = !reset && ((state == REPORT) || repeat_fire);
    assign key_held  = !reset && (state == HOLD) && S_Row;
    assign scan_miss = !reset && miss;
    assign state_dbg = state;

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Directed bench for keypad_col_scanner with a behavioural keypad matrix driving Row from Col.
// Build with +define+KEYPAD_REPEAT_EN to include the auto-repeat scenario.
module tb_keypad_col_scanner;

    localparam int SETTLE = 4;
    localparam int REPEAT = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] Row;
    logic       S_Row;
    logic [3:0] Col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       scan_miss;
    logic [1:0] state_dbg;

    logic [15:0] keys;
    logic        force_rows;
    logic [3:0]  row_model;
    logic        mon_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    keypad_col_scanner #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (8),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .Row      (Row),
        .S_Row    (S_Row),
        .Col      (Col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .scan_miss(scan_miss),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / keypad matrix ----------------
    always #5 clock = ~clock;

    // key index = row*4 + col; a row reads high when any pressed key in it has its column driven.
    always_comb begin
        row_model = 4'b0000;
        for (int r = 0; r < 4; r++) row_model[r] = |(keys[r*4 +: 4] & Col);
    end
    assign Row = force_rows ? 4'b1111 : row_model;

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every key_valid must match the next expected code.
    always @(negedge clock) begin
        if (mon_en) begin
            check("valid_miss_exclusive", 32'(key_valid & scan_miss), 32'd0);
            if (key_valid === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected_key_valid", 32'd1, 32'd0);
                else check("sb_key_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic release_all(input int n);
        keys  = 16'h0000;
        S_Row = 1'b0;
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] exp_col;
        logic       exp_kv;

        reset      = 1'b1;
        S_Row      = 1'b1;
        force_rows = 1'b1;
        keys       = 16'h0000;
        tick();
        tick();
        check("rst_col", 32'(Col), 32'hF);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        check("rst_scan_miss", 32'(scan_miss), 32'd0);
        reset      = 1'b0;
        S_Row      = 1'b0;
        force_rows = 1'b0;
        check("rst_state_idle", 32'(state_dbg), 32'd0);
        mon_en = 1'b1;
        tick();
        check("post_rst_state", 32'(state_dbg), 32'd0);
        tick();

        // Single key 9 (row 2, col 1): hit at t0 + 2*SETTLE + 1.
        keys  = 16'h0001 << 9;
        S_Row = 1'b1;
        exp_q.push_back(4'd9);
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_col = (k <= 4) ? 4'b0001 : (k <= 8) ? 4'b0010 : 4'b1111;
            check($sformatf("single_col_k%0d", k), 32'(Col), 32'(exp_col));
            check($sformatf("single_kv_k%0d", k), 32'(key_valid), (k == 9) ? 32'd1 : 32'd0);
        end
        check("single_key_code", 32'(key_code), 32'd9);
        tick();
        check("single_hold_state", 32'(state_dbg), 32'd3);
        check("single_key_held", 32'(key_held), 32'd1);
        check("single_hold_col", 32'(Col), 32'hF);
        repeat (3) tick();
        check("single_held_later", 32'(key_held), 32'd1);
        S_Row = 1'b0;
        keys  = 16'h0000;
        #1;
        check("single_release_held", 32'(key_held), 32'd0);
        tick();
        check("single_release_state", 32'(state_dbg), 32'd0);
        check("single_release_col", 32'(Col), 32'hF);
        check("single_code_kept", 32'(key_code), 32'd9);
        tick();

        // Glitch: one-cycle S_Row with nothing pressed -> four windows then a miss.
        S_Row = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            S_Row = 1'b0;
            if (k <= 16) begin
                exp_col = 4'b0001 << ((k - 1) / 4);
                check($sformatf("glitch_col_k%0d", k), 32'(Col), 32'(exp_col));
            end
            check($sformatf("glitch_miss_k%0d", k), 32'(scan_miss), (k == 16) ? 32'd1 : 32'd0);
        end
        check("glitch_state_idle", 32'(state_dbg), 32'd0);
        check("glitch_code_kept", 32'(key_code), 32'd9);
        tick();

        // Multi-key: 14 (row 3, col 2) and 3 (row 0, col 3); column 2 wins.
        keys  = (16'h0001 << 14) | (16'h0001 << 3);
        S_Row = 1'b1;
        exp_q.push_back(4'd14);
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("multi_kv_k%0d", k), 32'(key_valid), (k == 13) ? 32'd1 : 32'd0);
        end
        check("multi_key_code", 32'(key_code), 32'd14);
        repeat (4) tick();
        release_all(3);

        // Reset while column 2 is being driven: abort, no strobe.
        keys  = 16'h0001 << 15;
        S_Row = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        check("abort_col2", 32'(Col), 32'b0100);
        reset = 1'b1;
        tick();
        check("abort_col", 32'(Col), 32'hF);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_key_valid", 32'(key_valid), 32'd0);
        check("abort_scan_miss", 32'(scan_miss), 32'd0);
        check("abort_key_held", 32'(key_held), 32'd0);
        check("abort_key_code", 32'(key_code), 32'd0);
        reset = 1'b0;
        release_all(20);

`ifdef KEYPAD_REPEAT_EN
        // Key 5 held 35 cycles after REPORT: repeats at +10, +20, +30.
        keys  = 16'h0001 << 5;
        S_Row = 1'b1;
        repeat (4) exp_q.push_back(4'd5);
        for (int k = 1; k <= 44; k++) begin
            tick();
            exp_kv = (k == 9) || (k > 9 && ((k - 9) % 10) == 0);
            check($sformatf("repeat_kv_k%0d", k), 32'(key_valid), 32'(exp_kv));
        end
        S_Row = 1'b0;
        keys  = 16'h0000;
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("repeat_after_release_k%0d", k), 32'(key_valid), 32'd0);
        end
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_col_scanner.md
Name: keypad_col_scanner

Overview:
- Drives the four keypad column lines and identifies which key is pressed.
- Sits on the column side of the 4x4 lock keypad, paired with the row debouncer: the debouncer reports a debounced "any row active" level, and this block scans the columns to resolve the row/column pair.
- Emits a one-cycle key_valid strobe with a 4-bit key code to the lock controller, then waits for debounced release before re-arming.

Parameters:
- SETTLE_CYCLES, 16: cycles each column is driven before Row is sampled; legal range 3..255.
- CNT_W, 8: width of the settle/repeat counter; must hold SETTLE_CYCLES-1 and REPEAT_CYCLES-1.
- REPEAT_CYCLES, 200: auto-repeat interval; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Row  input  4  raw keypad rows, active-high, asynchronous to clock
- S_Row  input  1  debounced "any row active" from the row debouncer
- Col  output  4  column drive, active-high
- key_code  output  4  key index = row*4 + col
- key_valid  output  1  one-cycle strobe, key_code valid
- key_held  output  1  high while the resolved key is still debounced-pressed
- scan_miss  output  1  one-cycle strobe, scan found no key

Behaviour:
- Reset is synchronous and active-high. On a reset cycle:
  - state goes to IDLE, counter = 0, Col = 4'b1111.
  - key_code = 0, key_valid = 0, key_held = 0, scan_miss = 0.
  - The Row synchronizer flops clear to 0.
- A reset asserted mid-scan or in HOLD aborts immediately; no strobe is produced.
- Row passes through a 2-FF synchronizer (Row_s). All scan decisions use Row_s.
- IDLE:
  - Col = 4'b1111.
  - If S_Row = 1, go to SCAN with col index = 0 and counter = 0.
- SCAN:
  - Col = one-hot (1 << col index). S_Row is ignored in this state.
  - counter increments each cycle.
  - When counter = SETTLE_CYCLES-1, sample Row_s:
    - Row_s nonzero: latch key_code = {lowest set row index, col index} and go to REPORT.
    - Row_s zero and col index < 3: col index + 1, counter = 0, stay in SCAN.
    - Row_s zero and col index = 3: pulse scan_miss for 1 cycle and go to IDLE.
- Multiple keys pressed: the lowest column index wins; within that column, the lowest row index wins.
- REPORT:
  - key_valid = 1 for exactly 1 cycle, Col = 4'b1111.
  - Next state is HOLD.
- HOLD:
  - Col = 4'b1111, key_held = 1.
  - When S_Row = 0: key_held = 0 and go to IDLE.
- Latency: with S_Row first sampled high in IDLE at cycle t0, a key in column c gives key_valid at cycle t0 + (c+1)*SETTLE_CYCLES + 1.
- key_code holds its value until the next REPORT; it is not cleared by release or by a miss.
- key_valid and scan_miss are never asserted in the same cycle.
- A release during SCAN (Row_s drops) produces a miss or a later-column hit, decided by the sample point only; no special handling.
- A new press seen in HOLD is not reported until the full release cycle back through IDLE.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HOLD, the counter counts 0..REPEAT_CYCLES-1 while S_Row = 1.
  - At terminal count, pulse key_valid with the unchanged key_code and reset the counter.
  - The counter clears on entry to HOLD.
- Undefined:
  - Exactly one key_valid per press.
  - REPEAT_CYCLES is unused and no repeat logic is synthesized.

Test Plan:
- Reset: hold reset=1 for 2 cycles with Row=4'b1111 and S_Row=1 → Col=4'b1111, all outputs 0, state IDLE on the cycle after reset drops.
- Single key, SETTLE_CYCLES=4: Row[2] active only when Col[1] is high, S_Row rises at t0 → Col sequence 0001 (4 cycles) then 0010 (4 cycles); key_valid at t0+9 with key_code=9; key_held=1 until S_Row drops, then Col=1111 and state IDLE.
- Glitch: S_Row pulses high for 1 cycle, Row stays 0 → four column windows, then scan_miss=1 at t0+16; no key_valid.
- Multi-key: Row[3] active on Col[2] and Row[0] active on Col[3] → key_code=14 (column 2 wins); single key_valid.
- Reset during SCAN at column 2 → next cycle Col=1111 and outputs 0; no key_valid.
- KEYPAD_REPEAT_EN with REPEAT_CYCLES=10: key 5 held for 35 cycles after REPORT → three extra key_valid pulses 10 cycles apart, all with key_code=5; none after S_Row drops.
